// File: rtl/gs_bus_master.sv
// GS write-bus initiator: divides clk_100M down to bus_clk and replays queued register
// writes onto the bus, changing bus fields only on bus_clk falling edges.
module gs_bus_master #(
  parameter int CLK_DIV    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYC    = 0
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [15:0] req_gpreg,
  output logic        bus_clk,
  output logic        bus_valid,
  output logic [63:0] bus_addr,
  output logic [31:0] bus_data,
  output logic [15:0] bus_gpreg,
  output logic        busy,
  output logic [15:0] tx_count
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic [15:0] gpreg;
  } req_t;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP, DRAIN} state_t;

  logic [DW-1:0] div_cnt;
  logic          div_tc, fall_evt;
  req_t          mem [FIFO_DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcount, fcount_nxt;
  logic          rst_q, full, empty, push, pop, gap_last;
  logic [15:0]   gap_cnt;
  state_t        state;

  // Clock divider; a fall event is the terminal count while bus_clk is high.
  assign div_tc   = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = div_tc & bus_clk;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      div_cnt <= '0;
      bus_clk <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      bus_clk <= ~bus_clk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign full       = (fcount == (AW+1)'(FIFO_DEPTH));
  assign empty      = (fcount == '0);
  assign req_ready  = !rst_q & !full;
  assign push       = req_valid & req_ready;
  assign gap_last   = (gap_cnt == 16'(GAP_CYC - 1));
  assign head       = mem[rd_ptr];
  // Every state that can launch a write does so only on a fall event with data queued.
  assign pop        = fall_evt & !empty &
                      ((state == IDLE) | (state == DRAIN) |
                       ((state == DRIVE) & (GAP_CYC == 0)) |
                       ((state == GAP) & gap_last));
  assign fcount_nxt = fcount + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk_100M) begin
    if (push) mem[wr_ptr] <= '{addr: req_addr, data: req_data, gpreg: req_gpreg};
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      rst_q  <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      rst_q  <= 1'b0;
      fcount <= fcount_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state     <= IDLE;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      bus_gpreg <= '0;
      tx_count  <= '0;
      busy      <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      busy <= (state != IDLE) | (fcount_nxt != '0);
      if (fall_evt) begin
        if (pop) begin
          {bus_addr, bus_data, bus_gpreg} <= head;
          bus_valid <= 1'b1;
          tx_count  <= tx_count + 16'd1;
          state     <= DRIVE;
          busy      <= 1'b1;
        end else begin
          case (state)
            DRIVE: begin
              bus_valid <= 1'b0;
              gap_cnt   <= '0;
              state     <= (GAP_CYC > 0) ? GAP : DRAIN;
            end
            GAP: begin
              if (gap_last) state <= DRAIN;
              else          gap_cnt <= gap_cnt + 16'd1;
            end
            // One idle period lets the receiver commit before busy drops.
            DRAIN: begin
              state <= IDLE;
              busy  <= (fcount_nxt != '0);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gs_bus_master.sv
// Directed bench for gs_bus_master: one instance back-to-back (GAP_CYC=0), one with GAP_CYC=2,
// plus a receiver model that scoreboards every write sampled on a bus_clk rise.
module tb_gs_bus_master;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
    logic [15:0] g;
  } wr_t;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;

  logic        rv0 = 1'b0, rr0;
  logic [63:0] ra0 = '0;
  logic [31:0] rd0 = '0;
  logic [15:0] rg0 = '0;
  logic        bclk0, bval0, busy0;
  logic [63:0] baddr0;
  logic [31:0] bdata0;
  logic [15:0] bgp0, tx0;

  logic        rvg = 1'b0, rrg;
  logic [63:0] rag = '0;
  logic [31:0] rdg = '0;
  logic [15:0] rgg = '0;
  logic        bclkg, bvalg, busyg;
  logic [63:0] baddrg;
  logic [31:0] bdatag;
  logic [15:0] bgpg, txg;

  int          errs = 0;
  int          checks = 0;
  int          rx_n = 0;
  wr_t         exp_q[$];
  logic [63:0] gap_rx[$];
  logic [31:0] regs [0:7];

  always #5 clk_100M = ~clk_100M;

  gs_bus_master #(.CLK_DIV(5), .FIFO_DEPTH(8), .GAP_CYC(0)) u_dut (
    .clk_100M(clk_100M), .rst(rst),
    .req_valid(rv0), .req_ready(rr0), .req_addr(ra0), .req_data(rd0), .req_gpreg(rg0),
    .bus_clk(bclk0), .bus_valid(bval0), .bus_addr(baddr0), .bus_data(bdata0),
    .bus_gpreg(bgp0), .busy(busy0), .tx_count(tx0));

  gs_bus_master #(.CLK_DIV(5), .FIFO_DEPTH(8), .GAP_CYC(2)) u_gap (
    .clk_100M(clk_100M), .rst(rst),
    .req_valid(rvg), .req_ready(rrg), .req_addr(rag), .req_data(rdg), .req_gpreg(rgg),
    .bus_clk(bclkg), .bus_valid(bvalg), .bus_addr(baddrg), .bus_data(bdatag),
    .bus_gpreg(bgpg), .busy(busyg), .tx_count(txg));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model: samples on the rise, commits into a small register file.
  always @(posedge bclk0) begin
    if (bval0 === 1'b1) begin
      rx_n++;
      check("rx_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) check("rx_fields", 128'({baddr0, bdata0, bgp0}), 128'(exp_q.pop_front()));
      regs[baddr0[2:0]] = bdata0;
    end
  end

  always @(posedge bclkg) if (bvalg === 1'b1) gap_rx.push_back(baddrg);

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  function automatic logic sig(input bit sel, input bit use_busy);
    if (sel) return use_busy ? busyg : bvalg;
    return use_busy ? busy0 : bval0;
  endfunction

  task automatic wait_until(input bit sel, input bit use_busy, input logic lvl,
                            input string tag, output int n);
    n = 0;
    while (sig(sel, use_busy) !== lvl && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check({tag, "_timeout"}, 128'(sig(sel, use_busy)), 128'(lvl));
  endtask

  task automatic push(input bit sel, input logic [63:0] a, input logic [31:0] d,
                      input logic [15:0] g);
    int   n;
    logic rdy;
    n = 0;
    if (sel) begin rvg = 1'b1; rag = a; rdg = d; rgg = g; end
    else     begin rv0 = 1'b1; ra0 = a; rd0 = d; rg0 = g; end
    do begin
      rdy = sel ? rrg : rr0;
      tick();
      n++;
    end while (!rdy && n < 200);
    check("push_accepted", 128'(rdy), 128'(1));
    rv0 = 1'b0;
    rvg = 1'b0;
    if (!sel) exp_q.push_back({a, d, g});
  endtask

  task automatic align_rise();
    int n;
    n = 0;
    while (bclk0 !== 1'b0 && n < 50) begin tick(); n++; end
    while (bclk0 !== 1'b1 && n < 50) begin tick(); n++; end
    check("align_rise", 128'(bclk0), 128'(1));
  endtask

  initial begin
    int   n, bad, i, tx_base, rx_base;
    logic rdy, saw_full;

    // 1: reset values and divider phase
    repeat (3) tick();
    check("rst_bus_clk", 128'(bclk0), 128'(0));
    check("rst_fields", 128'({bval0, baddr0, bdata0, bgp0, tx0, busy0}), 128'(0));
    check("rst_ready", 128'(rr0), 128'(0));
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) check("ready_after_rst", 128'(rr0), 128'(1));
    end while (bclk0 !== 1'b1 && n < 50);
    check("first_rise", 128'(n), 128'(5));
    n = 0;
    do begin tick(); n++; end while (bclk0 !== 1'b0 && n < 50);
    do begin tick(); n++; end while (bclk0 !== 1'b1 && n < 50);
    check("bus_clk_period", 128'(n), 128'(10));

    // 2: single write
    push(0, 64'd2, 32'h1234, 16'hA5A5);
    wait_until(0, 0, 1'b1, "t2_valid", n);
    n = 0;
    bad = 0;
    while (bval0 === 1'b1 && n < 100) begin
      if ({baddr0, bdata0, bgp0} !== {64'd2, 32'h1234, 16'hA5A5}) bad++;
      tick();
      n++;
    end
    check("t2_valid_len", 128'(n), 128'(10));
    check("t2_fields_stable", 128'(bad), 128'(0));
    check("t2_fields_hold", 128'({baddr0, bdata0, bgp0}), {16'h0, 64'd2, 32'h1234, 16'hA5A5});
    check("t2_tx_count", 128'(tx0), 128'(1));
    wait_until(0, 1, 1'b0, "t2_busy", n);
    check("t2_busy_drop", 128'(n), 128'(10));
    check("t2_rx_n", 128'(rx_n), 128'(1));

    // 3: back-to-back burst of three
    align_rise();
    push(0, 64'd0, 32'h1, 16'h0001);
    push(0, 64'd1, 32'h1, 16'h0002);
    push(0, 64'd7, 32'h55, 16'h0003);
    wait_until(0, 0, 1'b1, "t3_valid", n);
    n = 0;
    while (bval0 === 1'b1 && n < 100) begin tick(); n++; end
    check("t3_valid_len", 128'(n), 128'(30));
    wait_until(0, 1, 1'b0, "t3_busy", n);
    check("t3_mtr_en", 128'(regs[0]), 128'(1));
    check("t3_mtr_dir", 128'(regs[1]), 128'(1));
    check("t3_dac_gain", 128'(regs[7]), 128'(32'h55));
    check("t3_tx_count", 128'(tx0), 128'(4));

    // 4: ten pushes with req_valid held; FIFO must fill at 8
    tx_base = int'(tx0);
    i = 0;
    n = 0;
    saw_full = 1'b0;
    rv0 = 1'b1; ra0 = 64'h100; rd0 = 32'hD0; rg0 = 16'h10;
    while (i < 10 && n < 500) begin
      rdy = rr0;
      tick();
      n++;
      if (rdy) begin
        exp_q.push_back({ra0, rd0, rg0});
        i++;
        ra0 = 64'h100 + 64'(i); rd0 = 32'hD0 + 32'(i); rg0 = 16'h10 + 16'(i);
      end
      if (!rr0 && !saw_full) begin
        saw_full = 1'b1;
        check("t4_full_depth", 128'(i - (int'(tx0) - tx_base)), 128'(8));
      end
    end
    rv0 = 1'b0;
    check("t4_all_accepted", 128'(i), 128'(10));
    check("t4_saw_full", 128'(saw_full), 128'(1));
    wait_until(0, 1, 1'b0, "t4_busy", n);
    check("t4_tx_count", 128'(tx0), 128'(14));
    check("t4_rx_n", 128'(rx_n), 128'(14));
    check("t4_sb_empty", 128'(exp_q.size()), 128'(0));

    // 5: GAP_CYC=2 instance, two writes
    push(1, 64'h20, 32'hA, 16'h1);
    push(1, 64'h21, 32'hB, 16'h2);
    wait_until(1, 0, 1'b1, "t5_valid1", n);
    wait_until(1, 0, 1'b0, "t5_valid1_end", n);
    wait_until(1, 0, 1'b1, "t5_valid2", n);
    check("t5_gap_len", 128'(n), 128'(20));
    wait_until(1, 1, 1'b0, "t5_busy", n);
    check("t5_tx_count", 128'(txg), 128'(2));
    check("t5_rx_n", 128'(gap_rx.size()), 128'(2));
    if (gap_rx.size() == 2) begin
      check("t5_order0", 128'(gap_rx[0]), 128'(64'h20));
      check("t5_order1", 128'(gap_rx[1]), 128'(64'h21));
    end

    // 6: reset during DRIVE with four still queued
    for (int k = 0; k < 5; k++) push(0, 64'h300 + 64'(k), 32'(k), 16'(k));
    wait_until(0, 0, 1'b1, "t6_valid", n);
    rx_base = rx_n;
    rst = 1'b1;
    tick();
    check("t6_rst_outputs", 128'({bclk0, bval0, baddr0, bdata0, bgp0, tx0, busy0}), 128'(0));
    check("t6_rst_ready", 128'(rr0), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    repeat (100) tick();
    check("t6_no_writes", 128'(rx_n), 128'(rx_base));
    check("t6_tx_count", 128'(tx0), 128'(0));
    check("t6_idle", 128'({bval0, busy0}), 128'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
